// File: rtl/uart_rx_byte_counter.sv
// 8N1 UART receiver with selectable baud rate, good-frame counter and
// sticky comparison against an externally supplied expected byte.
module uart_rx_byte_counter #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD0    = 9600,
  parameter int unsigned BAUD1    = 19200,
  parameter int unsigned BAUD2    = 57600,
  parameter int unsigned BAUD3    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] speed,
  input  logic [7:0] expected_num,
  input  logic       clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       mismatch,
  output logic [7:0] byte_count,
  output logic       busy
);

  localparam int unsigned DIV0 = CLK_FREQ / BAUD0;
  localparam int unsigned DIV1 = CLK_FREQ / BAUD1;
  localparam int unsigned DIV2 = CLK_FREQ / BAUD2;
  localparam int unsigned DIV3 = CLK_FREQ / BAUD3;
  localparam int unsigned DIV_A = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned DIV_B = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int unsigned CW = $clog2(DIV_MAX + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] div_sel, half;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    count_q, count_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          mis_q, mis_d;
  logic          good;
  logic          half_hit, div_hit;

  always_comb begin
    unique case (speed)
      2'd0: div_sel = CW'(DIV0);
      2'd1: div_sel = CW'(DIV1);
      2'd2: div_sel = CW'(DIV2);
      2'd3: div_sel = CW'(DIV3);
    endcase
  end

  assign half     = div_q >> 1;
  assign half_hit = (cnt_q == half - CW'(1));
  assign div_hit  = (cnt_q == div_q - CW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    good    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Speed is captured only here so a mid-frame change cannot disturb timing.
        if (rx_prev_q && !rx_s_q) begin
          div_d   = div_sel;
          state_d = START;
        end
      end
      START: begin
        if (half_hit) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (div_hit) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (div_hit) begin
          cnt_d = '0;
          if (rx_s_q) begin
            good    = 1'b1;
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    mis_d   = mis_q;
    if (clear) begin
      count_d = 8'h00;
      mis_d   = 1'b0;
    end else if (good) begin
      count_d = count_q + 8'd1;
      if (shift_q != expected_num) mis_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      count_q   <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      mis_q     <= mis_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign mismatch   = mis_q;
  assign byte_count = count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte_counter.sv
// Bench for uart_rx_byte_counter: vector table, hand-written corner cases and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_byte_counter;

  localparam int unsigned CLK_HZ = 1_152_000;
  localparam int unsigned B0 = 9600;
  localparam int unsigned B1 = 19200;
  localparam int unsigned B2 = 57600;
  localparam int unsigned B3 = 115200;

  logic       clk = 1'b0;
  logic       reset, rx, clear;
  logic [1:0] speed;
  logic [7:0] expected_num;
  logic [7:0] rx_data, byte_count;
  logic       rx_valid, frame_err, mismatch, busy;

  uart_rx_byte_counter #(
    .CLK_FREQ(CLK_HZ), .BAUD0(B0), .BAUD1(B1), .BAUD2(B2), .BAUD3(B3)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .speed(speed), .expected_num(expected_num),
    .clear(clear), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .mismatch(mismatch), .byte_count(byte_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] spd;
    logic [7:0] expn;
    logic       do_clear;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] got_q[$];
  int         divs[4];
  logic [7:0] m_count, m_data;
  logic       m_mis;
  vec_t       vecs[6];

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      got_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int div, input logic stop);
    rx = 1'b0;
    wait_clks(div);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(div);
    end
    rx = stop;
    wait_clks(div);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic [7:0] e, input logic ok);
    if (ok) begin
      m_count = m_count + 8'd1;
      m_data  = d;
      if (d != e) m_mis = 1'b1;
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "/rx_data"}, int'(rx_data), int'(m_data));
    check({tag, "/byte_count"}, int'(byte_count), int'(m_count));
    check({tag, "/mismatch"}, int'(mismatch), int'(m_mis));
    check({tag, "/busy"}, int'(busy), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    wait_clks(1);
    clear = 1'b0;
    m_count = 8'h00;
    m_mis   = 1'b0;
  endtask

  initial begin
    int v0, f0, lat, d, hold;
    logic [7:0] rd, re;
    logic [1:0] rs;
    logic       rstop;

    divs[0] = CLK_HZ / B0;
    divs[1] = CLK_HZ / B1;
    divs[2] = CLK_HZ / B2;
    divs[3] = CLK_HZ / B3;
    vecs[0] = '{8'hAB, 2'd3, 8'hAB, 1'b0};
    vecs[1] = '{8'h3C, 2'd0, 8'hAB, 1'b0};
    vecs[2] = '{8'hAB, 2'd3, 8'hAB, 1'b1};
    vecs[3] = '{8'h0F, 2'd1, 8'h0F, 1'b0};
    vecs[4] = '{8'hF0, 2'd2, 8'h0E, 1'b0};
    vecs[5] = '{8'h5A, 2'd3, 8'h5A, 1'b1};

    reset = 1'b0; rx = 1'b1; clear = 1'b0; speed = 2'd3; expected_num = 8'h00;
    m_count = 8'h00; m_data = 8'h00; m_mis = 1'b0;
    wait_clks(5);
    check("reset/rx_valid", int'(rx_valid), 0);
    check("reset/frame_err", int'(frame_err), 0);
    check_regs("reset");
    reset = 1'b1;
    wait_clks(5);

    // Table: good frames, each with a latency window check.
    for (int i = 0; i < 6; i++) begin
      speed = vecs[i].spd;
      expected_num = vecs[i].expn;
      d = divs[vecs[i].spd];
      v0 = valid_cnt; f0 = ferr_cnt;
      fork
        send_frame(vecs[i].data, d, 1'b1);
        begin
          lat = 0;
          for (int k = 0; k < 12 * d; k++) begin
            wait_clks(1);
            lat++;
            if (rx_valid) break;
          end
        end
      join
      wait_clks(3);
      model_frame(vecs[i].data, vecs[i].expn, 1'b1);
      check_range($sformatf("vec%0d/latency", i), lat, d / 2 + 9 * d + 1, d / 2 + 9 * d + 4);
      check($sformatf("vec%0d/valid_pulses", i), valid_cnt - v0, 1);
      check($sformatf("vec%0d/ferr_pulses", i), ferr_cnt - f0, 0);
      check_regs($sformatf("vec%0d", i));
      if (vecs[i].do_clear) begin
        do_clear();
        check_regs($sformatf("vec%0d_clr", i));
      end
    end

    // Framing error with the line held low afterwards.
    speed = 2'd2; expected_num = 8'h55;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, divs[2], 1'b0);
    wait_clks(290 - divs[2]);
    check("ferr/busy_held", int'(busy), 1);
    check("ferr/pulses", ferr_cnt - f0, 1);
    wait_clks(10);
    rx = 1'b1;
    wait_clks(5);
    check("ferr/valid_pulses", valid_cnt - v0, 0);
    check_regs("ferr");
    send_frame(8'h55, divs[2], 1'b1);
    wait_clks(3);
    model_frame(8'h55, 8'h55, 1'b1);
    check("ferr_next/valid_pulses", valid_cnt - v0, 1);
    check_regs("ferr_next");

    // Short glitch on an idle line must be rejected in START.
    speed = 2'd1;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(10);
    check("glitch/busy_start", int'(busy), 1);
    wait_clks(100);
    check("glitch/valid_pulses", valid_cnt - v0, 0);
    check("glitch/ferr_pulses", ferr_cnt - f0, 0);
    check_regs("glitch");

    // Reset during data bit 4 aborts the frame.
    speed = 2'd3; expected_num = 8'h81;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(divs[3]);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hE7 >> i);
      wait_clks(divs[3]);
    end
    rx = 1'b0;
    wait_clks(divs[3] / 2);
    reset = 1'b0;
    #1;
    check("abort/busy_in_reset", int'(busy), 0);
    rx = 1'b1;
    m_count = 8'h00; m_data = 8'h00; m_mis = 1'b0;
    wait_clks(4);
    reset = 1'b1;
    wait_clks(200);
    check("abort/valid_pulses", valid_cnt - v0, 0);
    check("abort/ferr_pulses", ferr_cnt - f0, 0);
    check_regs("abort");
    send_frame(8'h81, divs[3], 1'b1);
    wait_clks(3);
    model_frame(8'h81, 8'h81, 1'b1);
    check_regs("after_abort");

    // Clear held across the increment edge wins over it.
    expected_num = 8'h00;
    v0 = valid_cnt;
    fork
      send_frame(8'h77, divs[3], 1'b1);
      begin
        wait_clks(9 * divs[3]);
        clear = 1'b1;
        for (int k = 0; k < 3 * divs[3]; k++) begin
          wait_clks(1);
          if (rx_valid) break;
        end
        clear = 1'b0;
      end
    join
    wait_clks(3);
    m_count = 8'h00; m_mis = 1'b0; m_data = 8'h77;
    check("clr_valid/valid_pulses", valid_cnt - v0, 1);
    check_regs("clr_valid");

    // Randomized frames; speed is disturbed mid-frame and must be ignored.
    for (int n = 0; n < 16; n++) begin
      rd = 8'($urandom);
      rs = 2'($urandom_range(0, 3));
      re = ($urandom_range(0, 3) == 0) ? rd : 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      speed = rs; expected_num = re;
      d = divs[rs];
      v0 = valid_cnt; f0 = ferr_cnt;
      fork
        send_frame(rd, d, rstop);
        begin
          wait_clks(3 * d);
          speed = 2'($urandom_range(0, 3));
        end
      join
      if (!rstop) begin
        hold = $urandom_range(5, 50);
        wait_clks(hold);
        rx = 1'b1;
        wait_clks(5);
      end else begin
        wait_clks(3);
      end
      model_frame(rd, re, rstop);
      check($sformatf("rand%0d/valid_pulses", n), valid_cnt - v0, rstop ? 1 : 0);
      check($sformatf("rand%0d/ferr_pulses", n), ferr_cnt - f0, rstop ? 0 : 1);
      check_regs($sformatf("rand%0d", n));
      if ($urandom_range(0, 4) == 0) do_clear();
    end

    // 256 back-to-back frames at speed 2; count wraps on the last one.
    do_clear();
    speed = 2'd2; expected_num = 8'h10;
    v0 = valid_cnt; f0 = ferr_cnt;
    got_q.delete();
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), divs[2], 1'b1);
      model_frame(8'(i), 8'h10, 1'b1);
      if (i == 254) check("b2b/count_ff", int'(byte_count), int'(m_count));
    end
    wait_clks(3);
    check("b2b/valid_pulses", valid_cnt - v0, 256);
    check("b2b/ferr_pulses", ferr_cnt - f0, 0);
    check("b2b/recv_count", got_q.size(), 256);
    for (int i = 0; i < 256 && i < got_q.size(); i++)
      check($sformatf("b2b/byte%0d", i), int'(got_q[i]), i);
    check_regs("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
